// File: rtl/s2p_pkg.sv
// Shared definitions for the 4-lane serial-to-parallel receive stage.
package s2p_pkg;

  // Aligner states, numbered so they can be read directly off a waveform
  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    CHECK   = 2'd1,
    ALIGNED = 2'd2
  } state_t;

  localparam int         DEF_LANES     = 4;
  localparam int         DEF_WIDTH     = 8;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hBC;

endpackage

// File: rtl/s2p_lane_shift.sv
// One lane of the receiver: LSB-first right shift register. The incoming bit
// enters at the top, so after WIDTH valid bits the first bit sits in bit 0.
module s2p_lane_shift
  import s2p_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] sr,
  output logic [WIDTH-1:0] nx
);

  assign nx = {bit_in, sr[WIDTH-1:1]};

  // Shift only on cycles that carry a new bit; reset discards any partial word
  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (en) begin
      sr <= nx;
    end
  end

endmodule

// File: rtl/s2p_align_cond.sv
// Receive-side serial-to-parallel stage. Finds byte boundaries from a sync
// byte sent on all lanes, then delivers each non-sync word with a one-cycle
// strobe while tracking lock and the current bit position.
module s2p_align_cond
  import s2p_pkg::*;
#(
  parameter int               LANES      = DEF_LANES,
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] SYNC_BYTE  = WIDTH'(DEF_SYNC_BYTE),
  parameter int               LOCK_COUNT = 4,
  parameter int               ERR_LIMIT  = 3
) (
  input  logic                     IN_CLK_s2p,
  input  logic                     IN_RESET_s2p,
  input  logic [LANES-1:0]         IN_LANE_s2p,
  input  logic                     IN_VALID_s2p,
  output logic [WIDTH-1:0]         OUT_LANE3_s2p,
  output logic [WIDTH-1:0]         OUT_LANE2_s2p,
  output logic [WIDTH-1:0]         OUT_LANE1_s2p,
  output logic [WIDTH-1:0]         OUT_LANE0_s2p,
  output logic                     OUT_VALID_s2p,
  output logic                     OUT_LOCK_s2p,
  output logic [$clog2(WIDTH)-1:0] OUT_CTR_s2p
);

  localparam int CW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);

  state_t           state;
  logic [CW-1:0]    bit_ctr;
  logic [MW-1:0]    match_cnt;
  logic [EW-1:0]    err_cnt;
  logic             out_valid;
  logic             out_lock;
  logic [WIDTH-1:0] out_word [LANES];

  // The aligner decides from the next-value of each lane, so the registered
  // shift contents are not consumed here.
  logic [WIDTH-1:0] unused_sr [LANES];
  logic [WIDTH-1:0] nx [LANES];
  logic [LANES-1:0] lane_sync;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    s2p_lane_shift #(.WIDTH(WIDTH)) u_lane (
      .clk    (IN_CLK_s2p),
      .reset  (IN_RESET_s2p),
      .en     (IN_VALID_s2p),
      .bit_in (IN_LANE_s2p[gi]),
      .sr     (unused_sr[gi]),
      .nx     (nx[gi])
    );
    assign lane_sync[gi] = (nx[gi] == SYNC_BYTE);
  end

  logic all_sync;
  logic any_sync;
  logic word_end;

  assign all_sync = &lane_sync;
  assign any_sync = |lane_sync;
  assign word_end = (bit_ctr == CW'(WIDTH - 1));

  // Alignment FSM: sliding-window hunt, boundary confirmation, then data
  // delivery with a misalignment budget; all outputs are registered here.
  always_ff @(posedge IN_CLK_s2p) begin
    if (IN_RESET_s2p) begin
      state     <= SEEK;
      bit_ctr   <= '0;
      match_cnt <= '0;
      err_cnt   <= '0;
      out_valid <= 1'b0;
      out_lock  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        out_word[i] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (IN_VALID_s2p) begin
        case (state)
          SEEK: begin
            bit_ctr <= '0;
            if (all_sync) begin
              match_cnt <= MW'(1);
              if (LOCK_COUNT == 1) begin
                state    <= ALIGNED;
                out_lock <= 1'b1;
              end else begin
                state <= CHECK;
              end
            end
          end
          CHECK: begin
            bit_ctr <= bit_ctr + 1'b1;
            if (word_end) begin
              if (all_sync) begin
                if (match_cnt >= MW'(LOCK_COUNT - 1)) begin
                  match_cnt <= MW'(LOCK_COUNT);
                  state     <= ALIGNED;
                  out_lock  <= 1'b1;
                end else begin
                  match_cnt <= match_cnt + 1'b1;
                end
              end else begin
                state     <= SEEK;
                match_cnt <= '0;
              end
            end
          end
          ALIGNED: begin
            bit_ctr <= bit_ctr + 1'b1;
            if (word_end) begin
              if (all_sync) begin
                err_cnt <= '0;
              end else if (!any_sync) begin
                err_cnt   <= '0;
                out_valid <= 1'b1;
                for (int i = 0; i < LANES; i++) begin
                  out_word[i] <= nx[i];
                end
              end else if (err_cnt >= EW'(ERR_LIMIT - 1)) begin
                state     <= SEEK;
                out_lock  <= 1'b0;
                bit_ctr   <= '0;
                err_cnt   <= '0;
                match_cnt <= '0;
              end else begin
                err_cnt <= err_cnt + 1'b1;
              end
            end
          end
          default: begin
            state    <= SEEK;
            bit_ctr  <= '0;
            out_lock <= 1'b0;
          end
        endcase
      end
    end
  end

  assign OUT_LANE3_s2p = out_word[3];
  assign OUT_LANE2_s2p = out_word[2];
  assign OUT_LANE1_s2p = out_word[1];
  assign OUT_LANE0_s2p = out_word[0];
  assign OUT_VALID_s2p = out_valid;
  assign OUT_LOCK_s2p  = out_lock;
  assign OUT_CTR_s2p   = bit_ctr;

endmodule
